// File: rtl/btn_sw_conditioner.sv
// Button/switch front end for flag_capture: synchronises BTNL and SW and debounces the button.
// Emits one press pulse with the captured switch byte, and locks out after MAX_BYTES accepted presses.
module btn_sw_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 20,
    parameter int MAX_BYTES = 38
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTNL_raw,
    input  logic [7:0] SW_raw,
    output logic       btnl_pulse,
    output logic [7:0] sw_byte,
    output logic [5:0] press_count,
    output logic       all_done
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [5:0]       LP_MAX  = 6'(MAX_BYTES);

    logic             r_btn_m;
    logic             r_btn_s;
    logic [7:0]       r_sw_m;
    logic [7:0]       r_sw_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       w_count_next;

    assign w_count_next = press_count + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_m     <= 1'b0;
            r_btn_s     <= 1'b0;
            r_sw_m      <= 8'h00;
            r_sw_s      <= 8'h00;
            r_state     <= IDLE;
            r_cnt       <= '0;
            btnl_pulse  <= 1'b0;
            sw_byte     <= 8'h00;
            press_count <= 6'd0;
            all_done    <= 1'b0;
        end else begin
            r_btn_m    <= BTNL_raw;
            r_btn_s    <= r_btn_m;
            r_sw_m     <= SW_raw;
            r_sw_s     <= r_sw_m;
            btnl_pulse <= 1'b0;

            // Every state change clears the stability counter.
            case (r_state)
                IDLE: begin
                    if (r_btn_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_btn_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        if (!all_done) begin
                            btnl_pulse  <= 1'b1;
                            sw_byte     <= r_sw_s;
                            press_count <= w_count_next;
                            all_done    <= (w_count_next == LP_MAX);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!r_btn_s) begin
                        r_state <= REL_WAIT;
                        r_cnt   <= '0;
                    end
                end
                REL_WAIT: begin
                    if (r_btn_s) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (r_cnt == LP_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Directed bench for btn_sw_conditioner: press vector table plus bounce, reset, switch-hold and lockout sequences.
module tb_btn_sw_conditioner;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       BTNL_raw = 1'b0;
    logic [7:0] SW_raw = 8'h00;
    logic       btnl_pulse;
    logic [7:0] sw_byte;
    logic [5:0] press_count;
    logic       all_done;

    btn_sw_conditioner #(.DB_CYCLES(DB), .CNT_W(20), .MAX_BYTES(38)) dut (
        .clk         (clk),
        .rst         (rst),
        .BTNL_raw    (BTNL_raw),
        .SW_raw      (SW_raw),
        .btnl_pulse  (btnl_pulse),
        .sw_byte     (sw_byte),
        .press_count (press_count),
        .all_done    (all_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulses observed on the falling edge, with the posedge count at which each appeared.
    int pulse_cnt = 0;
    int last_pulse_cyc = -1;
    always @(negedge clk) begin
        if (btnl_pulse) begin
            pulse_cnt      = pulse_cnt + 1;
            last_pulse_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raw button high for 'hold' sampling edges, then low long enough to return to IDLE.
    task automatic press(input logic [7:0] sw, input int hold, output int pulses, output int start);
        int p0;
        @(posedge clk);
        #1;
        SW_raw   = sw;
        BTNL_raw = 1'b1;
        start    = cyc;
        p0       = pulse_cnt;
        tick(hold);
        BTNL_raw = 1'b0;
        tick(DB + 6);
        pulses = pulse_cnt - p0;
    endtask

    typedef struct {
        logic [7:0] sw;
        int         hold;
        int         exp_pulses;
        logic [7:0] exp_sw;
        int         exp_cnt;
        logic       exp_done;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int pulses;
        int start;
        int p0;
        int rstoff;
        int bounce_on[5];
        int bounce_off[3];

        vecs[0] = '{8'h41, 20, 1, 8'h41, 1, 1'b0};
        vecs[1] = '{8'h55,  2, 0, 8'h41, 1, 1'b0};
        vecs[2] = '{8'h66,  4, 0, 8'h41, 1, 1'b0};
        vecs[3] = '{8'h77,  5, 1, 8'h77, 2, 1'b0};
        vecs[4] = '{8'h10,  1, 0, 8'h77, 2, 1'b0};
        bounce_on  = '{1, 0, 1, 0, 1};
        bounce_off = '{0, 1, 0};

        tick(3);
        check("reset_pulse", int'(btnl_pulse), 0);
        check("reset_sw", int'(sw_byte), 0);
        check("reset_count", int'(press_count), 0);
        check("reset_done", int'(all_done), 0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 5; i++) begin
            press(vecs[i].sw, vecs[i].hold, pulses, start);
            check($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
            check($sformatf("vec%0d_sw", i), int'(sw_byte), int'(vecs[i].exp_sw));
            check($sformatf("vec%0d_count", i), int'(press_count), vecs[i].exp_cnt);
            check($sformatf("vec%0d_done", i), int'(all_done), int'(vecs[i].exp_done));
            if (vecs[i].exp_pulses == 1)
                check($sformatf("vec%0d_latency", i), last_pulse_cyc - start, DB + 3);
        end

        // Press bounce 1,0,1,0,1 then hold; release bounce 0,1,0 then low.
        @(posedge clk);
        #1;
        SW_raw = 8'h5A;
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            BTNL_raw = bounce_on[i][0];
            tick(1);
        end
        tick(12);
        for (int i = 0; i < 3; i++) begin
            BTNL_raw = bounce_off[i][0];
            tick(1);
        end
        tick(12);
        check("bounce_pulses", pulse_cnt - p0, 1);
        check("bounce_sw", int'(sw_byte), 8'h5A);
        check("bounce_count", int'(press_count), 3);

        // Switches change while the button is still held.
        @(posedge clk);
        #1;
        SW_raw = 8'h10;
        BTNL_raw = 1'b1;
        p0 = pulse_cnt;
        tick(12);
        check("swhold_sw_at_pulse", int'(sw_byte), 8'h10);
        SW_raw = 8'h20;
        tick(8);
        BTNL_raw = 1'b0;
        tick(DB + 6);
        check("swhold_pulses", pulse_cnt - p0, 1);
        check("swhold_sw_after", int'(sw_byte), 8'h10);
        check("swhold_count", int'(press_count), 4);

        // Reset while in PRESS_WAIT, button kept held through and after reset.
        @(posedge clk);
        #1;
        SW_raw = 8'h33;
        BTNL_raw = 1'b1;
        p0 = pulse_cnt;
        tick(4);
        rst = 1'b1;
        tick(1);
        check("midrst_pulse", int'(btnl_pulse), 0);
        check("midrst_sw", int'(sw_byte), 0);
        check("midrst_count", int'(press_count), 0);
        check("midrst_done", int'(all_done), 0);
        rst = 1'b0;
        rstoff = cyc;
        tick(14);
        BTNL_raw = 1'b0;
        tick(DB + 6);
        check("midrst_pulses", pulse_cnt - p0, 1);
        check("midrst_latency", last_pulse_cyc - rstoff, DB + 3);
        check("midrst_sw_after", int'(sw_byte), 8'h33);
        check("midrst_count_after", int'(press_count), 1);

        // Lockout: fresh count, 38 presses, then one more that must be ignored.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        for (int i = 1; i <= 38; i++) begin
            press(8'(i), 8, pulses, start);
            check($sformatf("lock_press%0d_pulses", i), pulses, 1);
            if (i == 37) check("lock_done_early", int'(all_done), 0);
        end
        check("lock_sw", int'(sw_byte), 8'h26);
        check("lock_count", int'(press_count), 38);
        check("lock_done", int'(all_done), 1);
        press(8'h27, 10, pulses, start);
        check("lock_extra_pulses", pulses, 0);
        check("lock_extra_sw", int'(sw_byte), 8'h26);
        check("lock_extra_count", int'(press_count), 38);
        check("lock_extra_done", int'(all_done), 1);

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("final_rst_count", int'(press_count), 0);
        check("final_rst_done", int'(all_done), 0);
        check("final_rst_sw", int'(sw_byte), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_sw_conditioner.md
Name: btn_sw_conditioner

Overview:
- Input front end that sits directly upstream of flag_capture and drives its BTNL and SW inputs.
- Synchronises the raw board switch bus and left push-button into the clk domain.
- Debounces the button and emits exactly one single-cycle press pulse per physical press, together with the switch byte captured on that same edge.
- Counts accepted presses up to the flag length, then blocks further presses so flag_capture never sees extra bytes.

Parameters:
- DB_CYCLES, 4, consecutive stable synchronised cycles needed to accept a press or a release; must be >= 2. Board builds override it to 500000.
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DB_CYCLES.
- MAX_BYTES, 38, number of accepted presses after which the block locks.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- BTNL_raw  input  1  asynchronous, bouncy left button (1 = pressed).
- SW_raw  input  8  asynchronous slide switches.
- btnl_pulse  output  1  one-cycle accepted-press strobe; connects to flag_capture BTNL.
- sw_byte  output  8  switch byte latched at the accepted press; connects to flag_capture SW.
- press_count  output  6  number of accepted presses, saturating at MAX_BYTES.
- all_done  output  1  high when press_count == MAX_BYTES.

Behaviour:
- Reset: one clk and one synchronous active-high reset, as already decided. When rst=1 at an edge, every register clears: synchronisers, state=IDLE, counter=0, btnl_pulse=0, sw_byte=8'h00, press_count=0, all_done=0. Reset wins over every other event, including a press in progress or a pulse due on that same edge.
- Synchronisers: two flip-flops each on BTNL_raw (giving btn_s) and on every SW_raw bit (giving sw_s). The second stage is the only copy used downstream.
- State machine, states IDLE, PRESS_WAIT, HELD, REL_WAIT; the counter clears on every state change:
  - IDLE: btn_s=1 -> PRESS_WAIT.
  - PRESS_WAIT: btn_s=0 -> IDLE, no pulse (a glitch). If btn_s=1 and counter==DB_CYCLES-1 -> HELD; btnl_pulse<=1 and sw_byte<=sw_s on this edge. Otherwise the counter increments.
  - HELD: stays while btn_s=1; btn_s=0 -> REL_WAIT.
  - REL_WAIT: btn_s=1 -> HELD, no new pulse (release bounce). If btn_s=0 and counter==DB_CYCLES-1 -> IDLE. Otherwise the counter increments.
- btnl_pulse: registered, and high for exactly one cycle per accepted press. A button held for any length of time produces one pulse only.
- Latency: with BTNL_raw stable high and the first sampling edge numbered 0, btnl_pulse is registered high at edge DB_CYCLES+2 and returns low at the next edge.
- sw_byte: changes only on an accepted-press edge; it is held at every other time. It is valid in the same cycle btnl_pulse is high and stays valid afterwards, so flag_capture may sample it with or after the pulse.
- press_count: increments on every accepted press. When press_count==MAX_BYTES, all_done=1. Further presses still walk the state machine, but btnl_pulse stays 0 and sw_byte and press_count do not change.
- SW_raw changing while the button is held has no effect until the next accepted press.
- Widths: press_count is 6 bits, which covers MAX_BYTES <= 63. The counter compare is unsigned at CNT_W bits.

Test Plan (DB_CYCLES=4):
1. Clean press: SW_raw=8'h41, BTNL_raw high for 20 cycles, then low -> exactly one btnl_pulse at edge 6, sw_byte=8'h41, press_count=1.
2. Glitch rejection: BTNL_raw high for 2 cycles, then low -> no pulse, press_count stays 0, state returns to IDLE.
3. Bounce: BTNL_raw toggles 1,0,1,0,1 and then holds high; on release it toggles 0,1,0 and then holds low -> exactly one pulse for the press and none on release.
4. Lockout: 38 clean presses with SW_raw = 1..38 -> sw_byte=8'h26 after the last, all_done=1, and a 39th press gives no pulse and leaves sw_byte=8'h26.
5. Reset mid-press: assert rst during PRESS_WAIT after 2 stable cycles -> no pulse, all outputs 0. The button still held after rst falls yields exactly one pulse at DB_CYCLES+2 edges after the first post-reset sampling edge.
6. Switch change while held: SW_raw goes 8'h10 -> 8'h20 after the pulse while the button is still held -> sw_byte stays 8'h10.
